// File: rtl/rtc_calendar_counter.sv
// rtl/rtc_calendar_counter.sv - 1 Hz prescaler plus binary calendar (sec..year) with field writes; optional alarm under RTC_CALENDAR_COUNTER_ALARM_EN
module rtc_calendar_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_valid,
    input  logic [2:0] set_field,
    input  logic [7:0] set_value,
    output logic       set_err,
    output logic       tick_1hz,
    output logic [7:0] second,
    output logic [7:0] minute,
    output logic [7:0] hour,
    output logic [7:0] day,
    output logic [7:0] month,
`ifdef RTC_CALENDAR_COUNTER_ALARM_EN
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_minute,
    input  logic       alarm_arm,
    output logic       alarm,
`endif
    output logic [7:0] year
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    localparam logic [2:0] F_SEC   = 3'd0;
    localparam logic [2:0] F_MIN   = 3'd1;
    localparam logic [2:0] F_HOUR  = 3'd2;
    localparam logic [2:0] F_DAY   = 3'd3;
    localparam logic [2:0] F_MONTH = 3'd4;
    localparam logic [2:0] F_YEAR  = 3'd5;

    // Days in month; every year divisible by 4 is leap within 2000..2099.
    function automatic logic [7:0] dim(input logic [7:0] mon, input logic [7:0] yr);
        case (mon)
            8'd2:                    return (yr[1:0] == 2'b00) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
            default:                 return 8'd31;
        endcase
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    pend_q, pend_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    day_q, day_d;
    logic [7:0]    month_q, month_d;
    logic [7:0]    year_q, year_d;
    logic          set_err_q, set_err_d;
    logic          tick_q, tick_d;
    logic          alarm_q, alarm_d;

    logic          tick_int;
    logic          wr_ok;
    logic          accept;
    logic          adv;
    logic [7:0]    dim_cur;
    logic [7:0]    dim_wr;
    logic          c_sec, c_min, c_hour, c_day, c_mon;
    logic [7:0]    nx_sec, nx_min, nx_hour, nx_day, nx_month, nx_year;

    // Carry chain: the complete next-second time, computed from the current fields.
    always_comb begin
        dim_cur  = dim(month_q, year_q);
        c_sec    = (sec_q == 8'd59);
        c_min    = c_sec && (min_q == 8'd59);
        c_hour   = c_min && (hour_q == 8'd23);
        c_day    = c_hour && (day_q >= dim_cur);
        c_mon    = c_day && (month_q == 8'd12);
        nx_sec   = c_sec  ? 8'd0 : sec_q + 8'd1;
        nx_min   = c_sec  ? (c_min  ? 8'd0 : min_q + 8'd1)   : min_q;
        nx_hour  = c_min  ? (c_hour ? 8'd0 : hour_q + 8'd1)  : hour_q;
        nx_day   = c_hour ? (c_day  ? 8'd1 : day_q + 8'd1)   : day_q;
        nx_month = c_day  ? (c_mon  ? 8'd1 : month_q + 8'd1) : month_q;
        nx_year  = c_mon  ? ((year_q == 8'd99) ? 8'd0 : year_q + 8'd1) : year_q;
    end

    // Write validation against the current calendar, and the dim that a month/year write would produce.
    always_comb begin
        wr_ok  = 1'b0;
        dim_wr = dim_cur;
        case (set_field)
            F_SEC, F_MIN: wr_ok = (set_value <= 8'd59);
            F_HOUR:       wr_ok = (set_value <= 8'd23);
            F_DAY:        wr_ok = (set_value != 8'd0) && (set_value <= dim_cur);
            F_MONTH: begin
                wr_ok  = (set_value != 8'd0) && (set_value <= 8'd12);
                dim_wr = dim(set_value, year_q);
            end
            F_YEAR: begin
                wr_ok  = (set_value <= 8'd99);
                dim_wr = dim(month_q, set_value);
            end
            default:      wr_ok = 1'b0;
        endcase
        accept = set_valid && wr_ok;
    end

    // Next state: prescaler, pending-tick bookkeeping, write or advance, output pulses.
    always_comb begin
        pre_d     = pre_q;
        pend_d    = pend_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        day_d     = day_q;
        month_d   = month_q;
        year_d    = year_q;
        tick_d    = 1'b0;
        alarm_d   = 1'b0;
        adv       = 1'b0;
        tick_int  = (pre_q == PRE_MAX);
        pre_d     = tick_int ? '0 : pre_q + 1'b1;
        set_err_d = set_valid && !wr_ok;

        if (accept) begin
            // A coincident tick is deferred, except that a seconds write restarts the second.
            if (tick_int && pend_q != 2'd3) begin
                pend_d = pend_q + 2'd1;
            end
            case (set_field)
                F_SEC: begin
                    sec_d  = set_value;
                    pre_d  = '0;
                    pend_d = 2'd0;
                end
                F_MIN:  min_d  = set_value;
                F_HOUR: hour_d = set_value;
                F_DAY:  day_d  = set_value;
                F_MONTH: begin
                    month_d = set_value;
                    day_d   = (day_q > dim_wr) ? dim_wr : day_q;
                end
                F_YEAR: begin
                    year_d = set_value;
                    day_d  = (day_q > dim_wr) ? dim_wr : day_q;
                end
                default: ;
            endcase
        end else if (tick_int || pend_q != 2'd0) begin
            adv = 1'b1;
            if (!tick_int) begin
                pend_d = pend_q - 2'd1;
            end
        end

        if (adv) begin
            sec_d   = nx_sec;
            min_d   = nx_min;
            hour_d  = nx_hour;
            day_d   = nx_day;
            month_d = nx_month;
            year_d  = nx_year;
            tick_d  = 1'b1;
`ifdef RTC_CALENDAR_COUNTER_ALARM_EN
            alarm_d = alarm_arm && (nx_sec == 8'd0) && (nx_min == alarm_minute)
                      && (nx_hour == alarm_hour);
`endif
        end
    end

    // State register; reset lands on 2000-01-01 00:00:00 with nothing pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q     <= '0;
            pend_q    <= 2'd0;
            sec_q     <= 8'd0;
            min_q     <= 8'd0;
            hour_q    <= 8'd0;
            day_q     <= 8'd1;
            month_q   <= 8'd1;
            year_q    <= 8'd0;
            set_err_q <= 1'b0;
            tick_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            pend_q    <= pend_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            day_q     <= day_d;
            month_q   <= month_d;
            year_q    <= year_d;
            set_err_q <= set_err_d;
            tick_q    <= tick_d;
            alarm_q   <= alarm_d;
        end
    end

    assign set_err  = set_err_q;
    assign tick_1hz = tick_q;
    assign second   = sec_q;
    assign minute   = min_q;
    assign hour     = hour_q;
    assign day      = day_q;
    assign month    = month_q;
    assign year     = year_q;
`ifdef RTC_CALENDAR_COUNTER_ALARM_EN
    assign alarm    = alarm_q;
`else
    logic unused_alarm;
    assign unused_alarm = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_calendar_counter.sv
// tb/tb_rtc_calendar_counter.sv - directed plus random bench for rtc_calendar_counter against a seconds-of-day calendar model
module tb_rtc_calendar_counter;

    localparam int CLK_HZ = 4;

    logic       clk;
    logic       rst;
    logic       set_valid;
    logic [2:0] set_field;
    logic [7:0] set_value;
    logic       set_err;
    logic       tick_1hz;
    logic [7:0] second, minute, hour, day, month, year;
    logic [7:0] alarm_hour, alarm_minute;
    logic       alarm_arm;
    logic       alarm;

    int vectors = 0;
    int miscompares = 0;

    rtc_calendar_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk),
        .rst(rst),
        .set_valid(set_valid),
        .set_field(set_field),
        .set_value(set_value),
        .set_err(set_err),
        .tick_1hz(tick_1hz),
        .second(second),
        .minute(minute),
        .hour(hour),
        .day(day),
        .month(month),
`ifdef RTC_CALENDAR_COUNTER_ALARM_EN
        .alarm_hour(alarm_hour),
        .alarm_minute(alarm_minute),
        .alarm_arm(alarm_arm),
        .alarm(alarm),
`endif
        .year(year)
    );

`ifndef RTC_CALENDAR_COUNTER_ALARM_EN
    assign alarm = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: calendar as plain integers, seconds handled as seconds-of-day.
    int m_pre, m_pend, m_s, m_mi, m_h, m_d, m_mo, m_y;
    bit m_tick, m_err, m_alarm;

    function automatic int mdays(int mo, int y);
        int t[12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2 && (y % 4) == 0) return 29;
        return t[mo - 1];
    endfunction

    task automatic model_reset();
        m_pre = 0; m_pend = 0;
        m_s = 0; m_mi = 0; m_h = 0; m_d = 1; m_mo = 1; m_y = 0;
        m_tick = 0; m_err = 0; m_alarm = 0;
    endtask

    task automatic model_advance();
        int sod;
        sod = m_h * 3600 + m_mi * 60 + m_s + 1;
        if (sod == 86400) begin
            sod = 0;
            m_d = m_d + 1;
            if (m_d > mdays(m_mo, m_y)) begin
                m_d = 1;
                m_mo = m_mo + 1;
                if (m_mo > 12) begin
                    m_mo = 1;
                    m_y = (m_y + 1) % 100;
                end
            end
        end
        m_h = sod / 3600;
        m_mi = (sod / 60) % 60;
        m_s = sod % 60;
    endtask

    task automatic model_clock(bit v, int f, int val);
        bit tk, ok;
        tk = (m_pre == CLK_HZ - 1);
        case (f)
            0, 1: ok = (val <= 59);
            2: ok = (val <= 23);
            3: ok = (val >= 1 && val <= mdays(m_mo, m_y));
            4: ok = (val >= 1 && val <= 12);
            5: ok = (val <= 99);
            default: ok = 0;
        endcase
        m_pre = tk ? 0 : m_pre + 1;
        m_err = v && !ok;
        m_tick = 0;
        m_alarm = 0;
        if (v && ok) begin
            if (tk) m_pend++;
            case (f)
                0: begin m_s = val; m_pre = 0; m_pend = 0; end
                1: m_mi = val;
                2: m_h = val;
                3: m_d = val;
                4: begin m_mo = val; if (m_d > mdays(m_mo, m_y)) m_d = mdays(m_mo, m_y); end
                default: begin m_y = val; if (m_d > mdays(m_mo, m_y)) m_d = mdays(m_mo, m_y); end
            endcase
        end else begin
            if (tk) m_pend++;
            if (m_pend > 0) begin
                m_pend--;
                model_advance();
                m_tick = 1;
`ifdef RTC_CALENDAR_COUNTER_ALARM_EN
                m_alarm = alarm_arm && m_s == 0 && m_mi == alarm_minute && m_h == alarm_hour;
`endif
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tick_1hz", {31'd0, tick_1hz}, m_tick);
        chk("set_err", {31'd0, set_err}, m_err);
        chk("second", {24'd0, second}, m_s);
        chk("minute", {24'd0, minute}, m_mi);
        chk("hour", {24'd0, hour}, m_h);
        chk("day", {24'd0, day}, m_d);
        chk("month", {24'd0, month}, m_mo);
        chk("year", {24'd0, year}, m_y);
`ifdef RTC_CALENDAR_COUNTER_ALARM_EN
        chk("alarm", {31'd0, alarm}, m_alarm);
`endif
    endtask

    // One clock: drive, let the model take the same edge, sample 1 time unit after the edge.
    task automatic step(bit v, int f, int val);
        set_valid = v;
        set_field = 3'(f);
        set_value = 8'(val);
        model_clock(v, f, val);
        @(posedge clk);
        #1;
        set_valid = 1'b0;
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic sync_to_tick();
        for (int i = 0; i < 2 * CLK_HZ && m_pre != CLK_HZ - 1; i++) step(0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        set_valid = 1'b0;
        set_field = 3'd0;
        set_value = 8'd0;
        alarm_hour = 8'd7;
        alarm_minute = 8'd30;
        alarm_arm = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;

        // Free run from reset: ticks every fourth cycle.
        idle(12);
        chk("t1_second", {24'd0, second}, 3);

        // Full rollover 2099-12-31 23:59:59 -> 2000-01-01 00:00:00.
        step(1, 5, 99); step(1, 4, 12); step(1, 3, 31);
        step(1, 2, 23); step(1, 1, 59); step(1, 0, 59);
        idle(4);
        chk("t2_tick", {31'd0, tick_1hz}, 1);
        chk("t2_year", {24'd0, year}, 0);
        chk("t2_day", {24'd0, day}, 1);

        // Leap day in 2004, none in 2005.
        step(1, 5, 4); step(1, 4, 2); step(1, 3, 28);
        step(1, 2, 23); step(1, 1, 59); step(1, 0, 59);
        idle(4);
        chk("t3_feb29", {24'd0, day}, 29);
        step(1, 5, 5);
        chk("t3_clamp28", {24'd0, day}, 28);
        step(1, 2, 23); step(1, 1, 59); step(1, 0, 59);
        idle(4);
        chk("t3_mar", {24'd0, month}, 3);
        chk("t3_mar1", {24'd0, day}, 1);

        // Rejected writes and month clamping.
        step(1, 4, 4);
        step(1, 3, 31);
        chk("t4_err", {31'd0, set_err}, 1);
        step(1, 6, 1); step(1, 7, 0); step(1, 0, 60); step(1, 4, 0); step(1, 4, 13);
        step(1, 5, 100); step(1, 2, 24); step(1, 3, 0);
        step(1, 4, 1); step(1, 3, 31); step(1, 5, 1); step(1, 4, 2);
        chk("t4_clamp", {24'd0, day}, 28);

        // Write coincident with a tick.
        sync_to_tick();
        step(1, 1, 10);
        chk("t5_min", {24'd0, minute}, 10);
        chk("t5_notick", {31'd0, tick_1hz}, 0);
        step(0, 0, 0);
        chk("t5_late_tick", {31'd0, tick_1hz}, 1);
        sync_to_tick();
        step(1, 0, 30);
        chk("t5_sec30", {24'd0, second}, 30);
        idle(3);
        chk("t5_no_tick_yet", {31'd0, tick_1hz}, 0);
        idle(1);
        chk("t5_sec31", {24'd0, second}, 31);

        // Reset in the middle of a pending tick.
        sync_to_tick();
        step(1, 1, 5);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_sec", {24'd0, second}, 0);
        chk("rst_day", {24'd0, day}, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

`ifdef RTC_CALENDAR_COUNTER_ALARM_EN
        alarm_arm = 1'b1;
        step(1, 2, 7); step(1, 1, 29); step(1, 0, 59);
        idle(4);
        chk("t6_alarm", {31'd0, alarm}, 1);
        alarm_arm = 1'b0;
        step(1, 1, 29); step(1, 0, 59);
        idle(4);
        chk("t6_no_alarm", {31'd0, alarm}, 0);
        alarm_arm = 1'b1;
`endif

        // Random writes, including invalid fields and values, mixed with free running.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0)
                step(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 100)));
            else
                step(0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
